// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage that sits in front of the 8-bit ALU.
// It holds a 4-entry register file and a per-register busy scoreboard. An issue
// reads two source registers into a one-deep output register (opa/opb feed ALU
// in1/in2), and the ALU result comes back through the write-back port.
// Optional feature (macro ALU_OPSTAGE_FWD_EN): a write-back in the issue cycle is
// bypassed to the read ports, so the issue does not stall on that busy source.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   iss_valid/iss_ready         issue handshake (iss_ready is combinational)
//   iss_ra, iss_rb, iss_rd      source A/B and destination addresses
//   iss_we                      issue writes iss_rd (sets its busy bit)
//   op_valid/op_ready           output handshake toward the ALU
//   opa, opb, op_rd, op_we      registered operand set
//   wb_en, wb_addr, wb_data     write-back from the ALU result path
//   busy                        scoreboard bits (debug)
module alu_operand_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [1:0]        iss_ra,
    input  logic [1:0]        iss_rb,
    input  logic [1:0]        iss_rd,
    input  logic              iss_we,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [1:0]        op_rd,
    output logic              op_we,
    input  logic              wb_en,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   busy
);

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   busy_nxt;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              fwd_a;
    logic              fwd_b;
    logic              slot_free;
    logic              hazard;
    logic              iss_fire;

    // Same-cycle write-back match on each read port
`ifdef ALU_OPSTAGE_FWD_EN
    assign fwd_a = wb_en && (wb_addr == iss_ra);
    assign fwd_b = wb_en && (wb_addr == iss_rb);
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // Read ports: register content, or bypassed write-back data on a match
    assign rd_a = fwd_a ? wb_data : rf[iss_ra];
    assign rd_b = fwd_b ? wb_data : rf[iss_rb];

    // One-deep output slot frees up when the current set is being consumed
    assign slot_free = !op_valid || op_ready;
    assign hazard    = (busy[iss_ra] && !fwd_a) || (busy[iss_rb] && !fwd_b);
    assign iss_ready = slot_free && !hazard;
    assign iss_fire  = iss_valid && iss_ready;

    // Scoreboard update: write-back clears first so an issue-set on the same address wins
    always_comb begin
        busy_nxt = busy;
        if (wb_en) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (iss_fire && iss_we) begin
            busy_nxt[iss_rd] = 1'b1;
        end
    end

    // Register file and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_en) begin
                rf[wb_addr] <= wb_data;
            end
            busy <= busy_nxt;
        end
    end

    // Output operand register; holds while op_valid and not op_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            op_rd    <= 2'b00;
            op_we    <= 1'b0;
        end else if (iss_fire) begin
            op_valid <= 1'b1;
            opa      <= rd_a;
            opb      <= rd_b;
            op_rd    <= iss_rd;
            op_we    <= iss_we;
        end else if (op_valid && op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Issued operand sets push their
// hand-computed expected values into a queue; a monitor pops and compares
// each time the DUT transfers an operand set.
module tb_alu_operand_stage;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] rd;
        logic       we;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iss_valid = 1'b0;
    logic       iss_ready;
    logic [1:0] iss_ra = 2'd0;
    logic [1:0] iss_rb = 2'd0;
    logic [1:0] iss_rd = 2'd0;
    logic       iss_we = 1'b0;
    logic       op_valid;
    logic       op_ready = 1'b1;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [1:0] op_rd;
    logic       op_we;
    logic       wb_en = 1'b0;
    logic [1:0] wb_addr = 2'd0;
    logic [7:0] wb_data = 8'h00;
    logic [3:0] busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    alu_operand_stage #(.DATA_W(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rd(iss_rd), .iss_we(iss_we),
        .op_valid(op_valid), .op_ready(op_ready),
        .opa(opa), .opb(opb), .op_rd(op_rd), .op_we(op_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an issue, wait (bounded) for acceptance, record expected operands
    task automatic do_issue(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                            input logic we, input logic [7:0] ea, input logic [7:0] eb,
                            output int waited);
        exp_t e;
        iss_valid = 1'b1;
        iss_ra = ra; iss_rb = rb; iss_rd = rd; iss_we = we;
        #1;
        waited = 0;
        while (!iss_ready && waited < 20) begin
            step();
            waited++;
        end
        n_tests++;
        if (!iss_ready) begin
            n_fail++;
            $display("FAIL issue_timeout: ra=%0d rb=%0d never accepted", ra, rb);
        end else begin
            e.a = ea; e.b = eb; e.rd = rd; e.we = we;
            sb_q.push_back(e);
        end
        step();
        iss_valid = 1'b0;
    endtask

    // Monitor: an operand set transfers at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && op_valid && op_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL op_unexpected: opa=%0h opb=%0h with empty queue", opa, opb);
            end else begin
                e = sb_q.pop_front();
                if (opa !== e.a || opb !== e.b || op_rd !== e.rd || op_we !== e.we) begin
                    n_fail++;
                    $display("FAIL op_data: got a=%0h b=%0h rd=%0d we=%0b expected a=%0h b=%0h rd=%0d we=%0b",
                             opa, opb, op_rd, op_we, e.a, e.b, e.rd, e.we);
                end
            end
        end
    end

    initial begin
        int w;
        logic [7:0] init_vals [4];
        init_vals[0] = 8'h11; init_vals[1] = 8'h22; init_vals[2] = 8'h33; init_vals[3] = 8'h44;

        // Test 1: reset state, load registers, simple issue
        #12;
        check("reset_op_valid", 32'(op_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_opa", 32'(opa), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            wb_en = 1'b1; wb_addr = 2'(i); wb_data = init_vals[i];
            step();
        end
        wb_en = 1'b0;
        do_issue(2'd1, 2'd2, 2'd0, 1'b0, 8'h22, 8'h33, w);
        check("t1_wait", 32'(w), 32'd0);
        check("t1_op_valid", 32'(op_valid), 32'd1);
        step();

        // Test 2: RAW hazard stalls until write-back
        do_issue(2'd0, 2'd0, 2'd3, 1'b1, 8'h11, 8'h11, w);
        iss_valid = 1'b1; iss_ra = 2'd3; iss_rb = 2'd0; iss_rd = 2'd0; iss_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t2_stall_ready", 32'(iss_ready), 32'd0);
            check("t2_busy", 32'(busy), 32'h8);
            step();
        end
        iss_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h77;
        step();
        wb_en = 1'b0;
        #1;
        check("t2_busy_clear", 32'(busy), 32'd0);
        do_issue(2'd3, 2'd1, 2'd0, 1'b0, 8'h77, 8'h22, w);
        check("t2_wait", 32'(w), 32'd0);
        step();

        // Test 3: write-back in the issue cycle of a busy source
        do_issue(2'd0, 2'd0, 2'd3, 1'b1, 8'h11, 8'h11, w);
        iss_valid = 1'b1; iss_ra = 2'd3; iss_rb = 2'd1; iss_rd = 2'd0; iss_we = 1'b0;
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h5A;
        #1;
`ifdef ALU_OPSTAGE_FWD_EN
        check("t3_fwd_ready", 32'(iss_ready), 32'd1);
        sb_q.push_back('{a: 8'h5A, b: 8'h22, rd: 2'd0, we: 1'b0});
        step();
        wb_en = 1'b0; iss_valid = 1'b0;
`else
        check("t3_nofwd_stall", 32'(iss_ready), 32'd0);
        step();
        wb_en = 1'b0;
        #1;
        check("t3_nofwd_ready", 32'(iss_ready), 32'd1);
        sb_q.push_back('{a: 8'h5A, b: 8'h22, rd: 2'd0, we: 1'b0});
        step();
        iss_valid = 1'b0;
`endif
        #1;
        check("t3_busy", 32'(busy), 32'd0);
        step();

        // Test 4: downstream stall holds operands, then full-rate transfers
        op_ready = 1'b0;
        do_issue(2'd1, 2'd2, 2'd0, 1'b0, 8'h22, 8'h33, w);
        iss_valid = 1'b1; iss_ra = 2'd0; iss_rb = 2'd3; iss_rd = 2'd0; iss_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_stall_ready", 32'(iss_ready), 32'd0);
            check("t4_hold", {16'h0, opa, opb}, 32'h2233);
            step();
        end
        op_ready = 1'b1;
        do_issue(2'd0, 2'd3, 2'd0, 1'b0, 8'h11, 8'h5A, w);
        check("t4_b2b_0", 32'(w), 32'd0);
        do_issue(2'd2, 2'd1, 2'd1, 1'b0, 8'h33, 8'h22, w);
        check("t4_b2b_1", 32'(w), 32'd0);
        check("t4_valid", 32'(op_valid), 32'd1);
        step();

        // Test 5: issue-set beats write-back clear on the same register
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h99;
        do_issue(2'd0, 2'd0, 2'd2, 1'b1, 8'h11, 8'h11, w);
        wb_en = 1'b0;
        check("t5_busy", 32'(busy), 32'h4);
        step();

        // Test 6: reset mid-stream discards operands and scoreboard
        op_ready = 1'b0;
        do_issue(2'd0, 2'd0, 2'd1, 1'b1, 8'h11, 8'h11, w);
        check("t6_pre_valid", 32'(op_valid), 32'd1);
        check("t6_pre_busy", 32'(busy), 32'h6);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(op_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        step();
        rst_n = 1'b1;
        op_ready = 1'b1;
        step();
        do_issue(2'd0, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, w);
        do_issue(2'd2, 2'd3, 2'd0, 1'b0, 8'h00, 8'h00, w);

        // Drain: every expected set must have been observed
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
